// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int MAX_WAIT_DEF = 4;
  localparam int TIMEOUT_DEF  = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_sat_counter.sv
// Clear/increment counter that saturates at MAX; clear has priority over increment.
module arb_sat_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst)                            count <= '0;
    else if (clr)                        count <= '0;
    else if (inc && (count != W'(MAX)))  count <= count + 1'b1;
  end

  assign at_max = (count == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one memory port, with
// fetch anti-starvation and a BUSY-state timeout that reports bus_err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              pipe_hold,
  output logic              bus_err,
  output arb_state_e        state_dbg
);

  // Handshake: a requester holds req/addr/we/wdata until its one-cycle valid
  // pulse; the arbiter holds mem_req and mem_* until the cycle mem_ack=1.
  arb_state_e state, next_state;
  logic grant_if, grant_d, ack_done, tmo_hit;
  logic wait_full, tmo_full, busy;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  assign busy = (state == IF_BUSY) || (state == D_BUSY);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    ack_done   = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(if_req && wait_full)) begin
          grant_d    = 1'b1;
          next_state = D_BUSY;
        end else if (if_req) begin
          grant_if   = 1'b1;
          next_state = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        // An ack in the timeout cycle still counts as a normal completion.
        if (mem_ack) begin
          ack_done   = 1'b1;
          next_state = IDLE;
        end else if (tmo_full) begin
          tmo_hit    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  arb_sat_counter #(.MAX(MAX_WAIT), .W(WAIT_W)) u_wait_cnt (
    .clock  (clock),
    .rst    (rst),
    .clr    (grant_if || !if_req),
    .inc    (if_req),
    .count  (wait_cnt),
    .at_max (wait_full)
  );

  arb_sat_counter #(.MAX(TIMEOUT), .W(TMO_W)) u_tmo_cnt (
    .clock  (clock),
    .rst    (rst),
    .clr    (grant_if || grant_d),
    .inc    (busy && !mem_ack),
    .count  (tmo_cnt),
    .at_max (tmo_full)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      bus_err  <= 1'b0;
      if (grant_if || grant_d) begin
        mem_req   <= 1'b1;
        mem_addr  <= grant_d ? d_addr : if_addr;
        mem_we    <= grant_d && d_we;
        mem_wdata <= grant_d ? d_wdata : '0;
      end
      if (ack_done || tmo_hit) begin
        mem_req <= 1'b0;
        bus_err <= tmo_hit;
        if (state == IF_BUSY) begin
          if_valid <= 1'b1;
          if_rdata <= ack_done ? mem_rdata : '0;
        end else begin
          d_valid <= 1'b1;
          // Stores leave d_rdata alone unless they time out.
          if (tmo_hit)      d_rdata <= '0;
          else if (!mem_we) d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign pipe_hold = (if_req && !if_valid) || (d_req && !d_valid);
  assign state_dbg = state;

endmodule
